// File: rtl/ysyx_25020047_lsu_ctrl_if.sv
// rtl/ysyx_25020047_lsu_ctrl_if.sv - memory request/response bus between the LSU and memory
//
// Purpose: one bundle for the LSU's single-transaction memory channel.
// Signals:
//   mem_req_valid  LSU -> mem  request pending
//   mem_req_ready  mem -> LSU  request accepted
//   mem_addr       LSU -> mem  word-aligned address
//   mem_we         LSU -> mem  1 = write, 0 = read
//   mem_wdata      LSU -> mem  lane-replicated store data
//   mem_wmask      LSU -> mem  byte-lane write mask (0 for reads)
//   mem_resp_valid mem -> LSU  read data valid / write acknowledged
//   mem_rdata      mem -> LSU  raw memory word
// Modports: master (LSU side), slave (memory side).
interface ysyx_25020047_lsu_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_25020047_lsu_ctrl.sv
// rtl/ysyx_25020047_lsu_ctrl.sv - multi-cycle load/store unit between execute and writeback
//
// Purpose: accepts one operation at a time from execute, issues at most one
// memory transaction, aligns/extends load data and presents a writeback value.
// Non-memory operations pass through with one cycle of latency.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        execute handshake (in_ready high only in IDLE)
//   in_result, in_wdata        address-or-result, store data
//   in_read, in_write          load / store strobes (write wins if both)
//   in_size, in_sext, in_wen   access size, load sign-extend, writeback enable
//   mem                        memory bus (master modport)
//   out_valid / out_ready      writeback handshake
//   out_data, out_wen, out_err writeback value, enable, misaligned flag
// Configuration macro: YSYX_25020047_LSU_MISALIGN_CHK_EN enables the
// misaligned-access check; when undefined out_err is constantly 0.
module ysyx_25020047_lsu_ctrl (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [31:0]                     in_result,
  input  logic [31:0]                     in_wdata,
  input  logic                            in_read,
  input  logic                            in_write,
  input  logic [1:0]                      in_size,
  input  logic                            in_sext,
  input  logic                            in_wen,
  ysyx_25020047_lsu_ctrl_if.master        mem,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_data,
  output logic                            out_wen,
  output logic                            out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_wen_q, out_wen_d;
  logic        out_err_q, out_err_d;

  // Accept-time decode of the incoming operation.
  logic        acc_is_mem;
  logic        acc_err;
  logic [1:0]  acc_lane;
  logic [3:0]  acc_mask;
  logic [31:0] acc_wdata;

  assign acc_is_mem = in_write | in_read;
  assign acc_lane   = in_result[1:0];

`ifdef YSYX_25020047_LSU_MISALIGN_CHK_EN
  logic acc_misal;
  assign acc_misal = in_size[1] ? (acc_lane != 2'b00)
                                : (in_size[0] & acc_lane[0]);
  assign acc_err   = acc_is_mem & acc_misal;
`else
  assign acc_err   = 1'b0;
`endif

  always_comb begin
    acc_mask  = 4'b0000;
    acc_wdata = in_wdata;
    case (in_size)
      2'd0: begin
        acc_mask  = 4'b0001 << acc_lane;
        acc_wdata = {4{in_wdata[7:0]}};
      end
      2'd1: begin
        acc_mask  = 4'b0011 << {acc_lane[1], 1'b0};
        acc_wdata = {2{in_wdata[15:0]}};
      end
      default: begin
        acc_mask  = 4'b1111;
        acc_wdata = in_wdata;
      end
    endcase
    // Reads and suppressed (misaligned) stores never drive byte lanes.
    if (!in_write || acc_err) begin
      acc_mask = 4'b0000;
    end
  end

  // Load alignment: bring the addressed byte lane down to bit 0, then
  // truncate and extend according to the latched size.
  logic [31:0] ld_shifted;
  logic [31:0] ld_value;

  assign ld_shifted = mem.mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_value = ld_shifted;
    case (size_q)
      2'd0:    ld_value = {{24{sext_q & ld_shifted[7]}}, ld_shifted[7:0]};
      2'd1:    ld_value = {{16{sext_q & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_value = ld_shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    out_data_d = out_data_q;
    out_wen_d  = out_wen_q;
    out_err_d  = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d     = in_result;
          wdata_d    = acc_wdata;
          wmask_d    = acc_mask;
          we_d       = in_write & ~acc_err;
          size_d     = in_size;
          sext_d     = in_sext;
          out_err_d  = acc_err;
          // Stores and rejected accesses report the address; loads
          // overwrite this once the response arrives.
          out_data_d = in_result;
          out_wen_d  = in_wen & ~in_write & ~acc_err;
          state_d    = (acc_is_mem && !acc_err) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_resp_valid) begin
          if (!we_q) begin
            out_data_d = ld_value;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wmask_q    <= 4'd0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      out_data_q <= 32'd0;
      out_wen_q  <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      out_data_q <= out_data_d;
      out_wen_q  <= out_wen_d;
      out_err_q  <= out_err_d;
    end
  end

  // Every output comes from the state register or latched fields only.
  assign in_ready          = (state_q == S_IDLE);
  assign mem.mem_req_valid = (state_q == S_REQ);
  assign mem.mem_addr      = {addr_q[31:2], 2'b00};
  assign mem.mem_we        = we_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_wmask     = wmask_q;
  assign out_valid         = (state_q == S_DONE);
  assign out_data          = out_data_q;
  assign out_wen           = out_wen_q;
  assign out_err           = out_err_q;

endmodule

// File: doc/ysyx_25020047_lsu_ctrl.md
# ysyx_25020047_lsu_ctrl

Multi-cycle load/store unit sitting directly downstream of the execute stage in the NPC core. Consumes the execute stage's computed address/result together with its read/write strobes, issues a single memory transaction over a valid/ready request channel, aligns and extends load data, and hands a writeback value to the writeback stage over a valid/ready output channel. Non-memory operations pass through with one cycle of latency, so every instruction moves through this block uniformly.

## Interface
- Parameters: none; datapath fixed at 32 bits, byte-addressed, 4-byte memory word.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an operation
- in_ready  out  1  block can accept; high only in IDLE
- in_result  in  32  execute result: effective address for memory ops, writeback value otherwise
- in_wdata  in  32  store data (rs2)
- in_read  in  1  load operation
- in_write  in  1  store operation
- in_size  in  2  0 = byte, 1 = half, 2 = word; 3 treated as word
- in_sext  in  1  sign-extend load data (0 for lbu/lhu)
- in_wen  in  1  register writeback enable from execute
- mem_req_valid  out  1  memory request pending
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
- mem_we  out  1  1 = write, 0 = read
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte-lane write mask; 0 for reads
- mem_resp_valid  in  1  read data valid / write acknowledged
- mem_rdata  in  32  raw memory word
- out_valid  out  1  writeback data available
- out_ready  in  1  writeback stage accepts
- out_data  out  32  load value or passed-through result
- out_wen  out  1  register writeback enable
- out_err  out  1  misaligned access flag (only with YSYX_25020047_LSU_MISALIGN_CHK_EN; tied 0 otherwise)

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset -> IDLE.
- IDLE: in_ready = 1. On in_valid, latch all in_* fields. If in_write or in_read -> REQ; else -> DONE with out_data = in_result.
- in_write and in_read both high: write wins, read ignored.
- REQ: mem_req_valid = 1, request fields held stable until mem_req_ready; on handshake -> WAIT.
- WAIT: on mem_resp_valid -> DONE; loads latch aligned/extended data.
- DONE: out_valid = 1, outputs held stable until out_ready; on handshake -> IDLE.
- Store mask: byte 4'b0001 << addr[1:0]; half 4'b0011 << {addr[1],1'b0}; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load data: shifted = mem_rdata >> (8*addr[1:0]); byte/half truncated, then sign- or zero-extended by in_sext; word unmodified.
- Stores: out_wen = 0, out_data = address. Loads and pass-through: out_wen = latched in_wen.
- mem_resp_valid outside WAIT is ignored. mem_req_ready outside REQ is ignored.

## Timing
- Reset values: mem_req_valid 0, mem_we 0, mem_wmask 0, mem_addr 0, mem_wdata 0, out_valid 0, out_data 0, out_wen 0, out_err 0; in_ready 1 once rst_n deasserts (IDLE).
- Pass-through: accept in cycle N, out_valid in cycle N+1.
- Memory op, zero-wait memory: accept N, mem_req_valid N+1, response earliest N+2, out_valid N+3. Each stall cycle on mem_req_ready or mem_resp_valid adds one cycle.
- out_ready low holds DONE indefinitely; no new input accepted (single-entry, no overlap).
- rst_n asserted mid-transaction: immediate return to IDLE, mem_req_valid drops asynchronously, transaction abandoned; a late response is ignored.
- All outputs registered or decoded from state register only; no combinational path from mem_* inputs to out_*.

## Configuration
- YSYX_25020047_LSU_MISALIGN_CHK_EN defined: half access with addr[0] = 1 or word access with addr[1:0] != 0 skips REQ/WAIT, goes IDLE -> DONE with out_err = 1, out_wen = 0, out_data = address; no memory request issued.
- Undefined: no check; misaligned accesses issued with masks/shifts as above (upper lanes truncated); out_err tied 0.

## Test plan
- Pass-through: in_result 0x1234_5678, in_wen 1, no read/write -> out_valid next cycle, out_data 0x1234_5678, out_wen 1, mem_req_valid never high.
- sb: addr 0x8000_0003, wdata 0xAABB_CCDD -> mem_addr 0x8000_0000, mem_wmask 4'b1000, mem_wdata 0xDDDD_DDDD, mem_we 1; after ack out_wen 0.
- lbu vs lb: addr 0x8000_0002, mem_rdata 0x0080_0000 -> in_sext 0 gives 0x0000_0080, in_sext 1 gives 0xFFFF_FF80.
- Backpressure: mem_req_ready low 3 cycles, mem_resp_valid 2 cycles after handshake, out_ready low 2 cycles -> request fields and out_data stable throughout, in_ready 0 until out handshake, exactly one request.
- Reset mid-WAIT, then spurious mem_resp_valid -> state IDLE, out_valid stays 0, next op completes normally.
- With macro: lw at addr 0x8000_0002 -> out_err 1 at cycle N+1, no mem_req_valid; without macro same stimulus issues request with mem_addr 0x8000_0000.
